// File: rtl/count_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_sched_pkg
//  Purpose  : Shared definitions for the count_sched block. Holds the
//             scheduler state encoding, the default counter width and the
//             number of requesters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package count_sched_pkg;

    localparam int c_WIDTH_DEFAULT = 4;
    localparam int c_NUM_REQ       = 2;

    // Scheduler state: IDLE, RUN and DONE only.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/counter_en.sv
`default_nettype none
// ============================================================================
//  Module   : counter_en
//  Purpose  : WIDTH-bit up-counter with synchronous clear, load-zero and
//             count enable. Clear and load-zero both force the count to 0;
//             enable advances it by one; otherwise it holds.
//  Ports    : clk         - rising-edge clock
//             rst         - synchronous active-high clear
//             i_load_zero - force count to zero on the next edge
//             i_en        - increment on the next edge
//             o_count     - registered count value
//  Revision : 1.0 - initial release
// ============================================================================
module counter_en
    import count_sched_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_zero,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_load_zero) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
//  Module   : count_sched
//  Purpose  : Two-requester round-robin scheduler that lends a shared
//             counter to the winner. The counter runs from 0 up to the
//             winner's terminal count L (latched at grant), then a one-cycle
//             DONE state reports completion before returning to IDLE.
//             Dropping the granted request during RUN aborts the grant.
//  Ports    : clock   - rising-edge clock
//             clear   - synchronous active-high reset
//             req     - per-requester request (bit i = requester i)
//             len0    - terminal count for requester 0, sampled at grant
//             len1    - terminal count for requester 1, sampled at grant
//             gnt     - one-hot grant, 0 when idle
//             Q       - shared counter value
//             busy    - high in RUN and DONE
//             done    - one-cycle completion pulse
//             done_id - index of the completing requester
//  Revision : 1.0 - initial release
// ============================================================================
module count_sched
    import count_sched_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]     len0,
    input  logic [WIDTH-1:0]     len1,
    output logic [c_NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id
);

    // After reset the pointer claims requester 1 was served last, so
    // requester 0 wins the first contested arbitration.
    localparam logic c_PTR_RESET = 1'b1;

    state_t               r_state,   w_state_nxt;
    logic [c_NUM_REQ-1:0] r_gnt,     w_gnt_nxt;
    logic [WIDTH-1:0]     r_len,     w_len_nxt;
    logic                 r_ptr,     w_ptr_nxt;      // requester granted most recently
    logic                 r_busy,    w_busy_nxt;
    logic                 r_done,    w_done_nxt;
    logic                 r_done_id, w_done_id_nxt;

    logic                 w_winner;
    logic                 w_cnt_zero;
    logic                 w_cnt_en;
    logic [WIDTH-1:0]     w_count;

    // A lone requester always wins; on contention the one not served last wins.
    assign w_winner = (req == 2'b11) ? ~r_ptr : req[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_len_nxt     = r_len;
        w_ptr_nxt     = r_ptr;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_cnt_zero    = 1'b0;
        w_cnt_en      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (req != '0) begin
                    w_state_nxt = c_ST_RUN;
                    w_gnt_nxt   = w_winner ? 2'b10 : 2'b01;
                    w_len_nxt   = w_winner ? len1 : len0;
                    w_ptr_nxt   = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_cnt_zero  = 1'b1;
                end
            end
            c_ST_RUN: begin
                // Abort takes precedence over reaching the terminal count.
                if (!req[r_ptr]) begin
                    w_state_nxt = c_ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_zero  = 1'b1;
                end else if (w_count == r_len) begin
                    // Counter holds at L; done is registered so it lines up with DONE.
                    w_state_nxt   = c_ST_DONE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_ptr;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            c_ST_DONE: begin
                // Requests are ignored here; the counter keeps its final value.
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= c_ST_IDLE;
            r_gnt     <= '0;
            r_len     <= '0;
            r_ptr     <= c_PTR_RESET;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_len     <= w_len_nxt;
            r_ptr     <= w_ptr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
        end
    end

    counter_en #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk         (clock),
        .rst         (clear),
        .i_load_zero (w_cnt_zero),
        .i_en        (w_cnt_en),
        .o_count     (w_count)
    );

    assign gnt     = r_gnt;
    assign Q       = w_count;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule
`default_nettype wire

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter: WIDTH, 4, bit width of the shared counter and of each length field.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: clear  input  1  reset; synchronous, active-high.
REQ-004 Port: req  input  2  per-requester request; bit i = requester i.
REQ-005 Port: len0  input  WIDTH  terminal count for requester 0; sampled at grant.
REQ-006 Port: len1  input  WIDTH  terminal count for requester 1; sampled at grant.
REQ-007 Port: gnt  output  2  one-hot grant; 2'b00 when idle.
REQ-008 Port: Q  output  WIDTH  shared counter value.
REQ-009 Port: busy  output  1  high in RUN and DONE.
REQ-010 Port: done  output  1  single-cycle completion pulse.
REQ-011 Port: done_id  output  1  requester index that completed; valid when done=1.

Function
REQ-012 FSM states: IDLE, RUN, DONE; encoding is free, but exactly these three states.
REQ-013 IDLE with req!=0: next edge -> RUN; gnt set one-hot to the winner; L latched from the winner's len; Q <= 0; ptr records the winner.
REQ-014 Arbitration: round-robin; if both request, the requester not served last wins; after reset requester 0 has priority.
REQ-015 RUN: Q increments by 1 each cycle while Q != L.
REQ-016 RUN with Q == L: next edge -> DONE; Q holds at L.
REQ-017 DONE lasts exactly one cycle: done=1, done_id=winner, gnt held; next edge -> IDLE, gnt=0, Q holds.
REQ-018 Grant duration: gnt high for L+2 cycles (L+1 in RUN, 1 in DONE).
REQ-019 L=0: one RUN cycle with Q=0, then DONE.
REQ-020 L=2^WIDTH-1: Q reaches all-ones and never wraps to 0 within a grant.
REQ-021 Abort: granted req deasserted during RUN -> next edge -> IDLE, gnt=0, Q<=0, no done pulse; ptr still updated.
REQ-022 req changes in DONE are ignored; completion still reported.
REQ-023 len0/len1 changes after grant do not affect L.
REQ-024 At least one IDLE cycle separates consecutive grants; back-to-back requests are served alternately.
REQ-025 The non-granted requester's req is ignored until IDLE.

Reset
REQ-026 clear=1 at a rising edge: state=IDLE, gnt=0, Q=0, busy=0, done=0, done_id=0, ptr favours requester 0, L=0.
REQ-027 clear has priority over all other inputs, including mid-RUN and in DONE; no done pulse on the aborted grant.
REQ-028 With clear held high, outputs stay at their reset values regardless of req.

Structure
REQ-029 The shared package holds the state typedef (IDLE/RUN/DONE), the WIDTH default and the requester-count constant (2).
REQ-030 The counter is a separate sub-module, counter_en: WIDTH-bit up-counter with synchronous clear, load-zero and enable, driving Q.
REQ-031 Arbitration and the FSM live in count_sched; all outputs are registered.

Verification
REQ-032 clear high 34 ns then low; req=01, len0=3 -> gnt=01 for 5 cycles, Q=0,1,2,3,3; done=1, done_id=0 on the 5th cycle.
REQ-033 req=11 held continuously, len0=1, len1=2 -> grants alternate 01,10,01; done_id sequence 0,1,0; one idle cycle between grants.
REQ-034 len1=0, req=10 -> one RUN cycle with Q=0, then done=1 with done_id=1; gnt high for 2 cycles.
REQ-035 len0=15, req=01 -> Q counts 0..15, holds 15 in DONE, no wrap; gnt high for 17 cycles.
REQ-036 Grant with len0=10; req0 dropped at Q=4 -> gnt=0 and Q=0 next cycle; no done pulse; next req=11 grants requester 1.
REQ-037 clear pulsed for one cycle mid-RUN at Q=6 -> all outputs at reset values next cycle; no done pulse; requester 0 has priority afterward.
